// File: rtl/btn_mode_ctrl.sv
// Button-driven mode/enable controller with req/ack update handshake toward the config block.
// Build option: define BTN_CTRL_REPEAT_EN to enable hold-to-auto-repeat on increment/decrement.
module btn_mode_ctrl #(
  parameter int          MODE_NUM   = 8,
  parameter logic [23:0] LONG_CNT   = 24'd12_000_000,
  parameter logic [23:0] REPEAT_CNT = 24'd2_400_000,
  localparam int         MODE_W     = $clog2(MODE_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        btn_deb,
  output logic              cfg_req,
  input  logic              cfg_ack,
  output logic [MODE_W-1:0] cfg_mode,
  output logic              cfg_en,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_REL} state_t;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic              en;
  } cfg_t;

  state_t      r_state;
  cfg_t        r_cfg;
  logic [1:0]  r_act;
  logic        r_req;
  logic        r_busy;
  logic [3:0]  r_btn_q;
  logic [3:0]  w_pressed;
  logic        w_any;
  logic [1:0]  w_sel;

`ifdef BTN_CTRL_REPEAT_EN
  logic [23:0] r_cnt;
  logic        r_rpt;
  logic [23:0] w_thr;
  logic        w_last;

  assign w_thr  = r_rpt ? REPEAT_CNT : LONG_CNT;
  assign w_last = (r_cnt == w_thr - 24'd1);
`else
  logic w_unused_params;
  assign w_unused_params = ^{LONG_CNT, REPEAT_CNT};
`endif

  assign w_pressed = ~r_btn_q;
  assign w_any     = |w_pressed;

  // lowest pressed index wins
  always_comb begin
    w_sel = 2'd3;
    if (w_pressed[2]) w_sel = 2'd2;
    if (w_pressed[1]) w_sel = 2'd1;
    if (w_pressed[0]) w_sel = 2'd0;
  end

  function automatic cfg_t f_apply(input cfg_t c, input logic [1:0] a);
    cfg_t n;
    n = c;
    case (a)
      2'd0: n.mode = (c.mode == MODE_W'(MODE_NUM - 1)) ? '0 : c.mode + 1'b1;
      2'd1: n.mode = (c.mode == '0) ? MODE_W'(MODE_NUM - 1) : c.mode - 1'b1;
      2'd2: n.mode = '0;
      default: n.en = ~c.en;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cfg   <= '{mode: '0, en: 1'b1};
      r_act   <= 2'd0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_btn_q <= 4'hF;
`ifdef BTN_CTRL_REPEAT_EN
      r_cnt   <= 24'd0;
      r_rpt   <= 1'b0;
`endif
    end else begin
      r_btn_q <= btn_deb;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_act   <= w_sel;
            r_cfg   <= f_apply(r_cfg, w_sel);
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_REQ;
`ifdef BTN_CTRL_REPEAT_EN
            r_cnt   <= 24'd0;
            r_rpt   <= 1'b0;
`endif
          end
        end
        // setting is frozen until the consumer accepts it
        S_REQ: begin
          if (cfg_ack) begin
            r_req   <= 1'b0;
            r_state <= S_HOLD;
`ifdef BTN_CTRL_REPEAT_EN
            r_cnt   <= 24'd0;
`endif
          end
        end
        S_HOLD: begin
          if (!w_pressed[r_act]) begin
            r_state <= S_REL;
          end
`ifdef BTN_CTRL_REPEAT_EN
          else if (!r_act[1] && w_last) begin
            r_cfg   <= f_apply(r_cfg, r_act);
            r_rpt   <= 1'b1;
            r_cnt   <= 24'd0;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else begin
            r_cnt   <= r_cnt + 24'd1;
          end
`endif
        end
        S_REL: begin
          if (&r_btn_q) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_req  = r_req;
  assign cfg_mode = r_cfg.mode;
  assign cfg_en   = r_cfg.en;
  assign busy     = r_busy;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Bench for btn_mode_ctrl: per-cycle behavioural model plus hand-computed directed expectations.
module tb_btn_mode_ctrl;
  localparam int MN = 5;
  localparam int LC = 20;
  localparam int RC = 5;
  localparam int MW = $clog2(MN);

  logic          clk;
  logic          rst_n;
  logic [3:0]    btn_deb;
  logic          cfg_req;
  logic          cfg_ack;
  logic [MW-1:0] cfg_mode;
  logic          cfg_en;
  logic          busy;

  btn_mode_ctrl #(.MODE_NUM(MN), .LONG_CNT(24'(LC)), .REPEAT_CNT(24'(RC))) dut (
    .clk(clk), .rst_n(rst_n), .btn_deb(btn_deb), .cfg_req(cfg_req),
    .cfg_ack(cfg_ack), .cfg_mode(cfg_mode), .cfg_en(cfg_en), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_rise = 0;
  int rise_t [64];

  // behavioural model: pending flag, held button, countdown to next repeat
  int       m_mode;
  bit       m_en;
  bit       m_pend;
  bit       m_wait_all;
  int       m_held;
  int       m_left;
  logic [3:0] m_bq;

  task automatic m_reset();
    m_mode = 0; m_en = 1'b1; m_pend = 1'b0; m_wait_all = 1'b0;
    m_held = -1; m_left = 0; m_bq = 4'hF;
  endtask

  task automatic m_apply(input int b);
    case (b)
      0: m_mode = (m_mode + 1) % MN;
      1: m_mode = (m_mode + MN - 1) % MN;
      2: m_mode = 0;
      default: m_en = !m_en;
    endcase
  endtask

  task automatic m_step();
    logic [3:0] pr;
    pr = ~m_bq;
    if (!rst_n) begin
      m_reset();
    end else begin
      if (m_pend) begin
        if (cfg_ack) m_pend = 1'b0;
      end else if (m_wait_all) begin
        if (m_bq == 4'hF) m_wait_all = 1'b0;
      end else if (m_held >= 0) begin
        if (!pr[m_held]) begin
          m_held = -1;
          m_wait_all = 1'b1;
        end
`ifdef BTN_CTRL_REPEAT_EN
        else if (m_held < 2) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_apply(m_held);
            m_pend = 1'b1;
            m_left = RC;
          end
        end
`endif
      end else if (pr != 4'h0) begin
        for (int i = 3; i >= 0; i--) if (pr[i]) m_held = i;
        m_apply(m_held);
        m_pend = 1'b1;
        m_left = LC;
      end
      m_bq = btn_deb;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      m_step();
    end
  end

  // per-cycle comparison against the model, away from the active edge
  initial begin
    bit last_req;
    bit m_busy;
    last_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        m_busy = m_pend || m_held >= 0 || m_wait_all;
        n_chk++;
        if (cfg_req !== m_pend || int'(cfg_mode) != m_mode || cfg_en !== m_en || busy !== m_busy) begin
          n_fail++;
          $display("FAIL model cyc=%0d req/mode/en/busy got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                   cyc, cfg_req, cfg_mode, cfg_en, busy, m_pend, m_mode, m_en, m_busy);
        end
        if (cfg_req && !last_req) begin
          if (n_rise < 64) rise_t[n_rise] = cyc;
          n_rise++;
        end
        last_req = cfg_req;
      end else begin
        last_req = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tap(input int b);
    btn_deb = ~(4'b0001 << b);
    tick(2);
    btn_deb = 4'hF;
    tick(8);
  endtask

  initial begin
    int n0;
    int p;
    int exp5 [5];
    exp5 = '{1, 2, 3, 4, 0};
    btn_deb = 4'hF; cfg_ack = 1'b1; rst_n = 1'b0;
    m_reset();
    #12;
    chk("rst_req", cfg_req, 0);
    chk("rst_mode", cfg_mode, 0);
    chk("rst_en", cfg_en, 1);
    chk("rst_busy", busy, 0);
    #10 rst_n = 1'b1;
    tick(2);

    // single 3-cycle press, ack tied high
    btn_deb = 4'hE;
    tick(1); chk("t1_req_early", cfg_req, 0);
    tick(1); chk("t1_req", cfg_req, 1); chk("t1_mode", cfg_mode, 1); chk("t1_busy", busy, 1);
    tick(1); chk("t1_req_drop", cfg_req, 0);
    btn_deb = 4'hF;
    tick(8); chk("t1_busy_end", busy, 0); chk("t1_nreq", n_rise, 1);

    // wrap behaviour
    tap(2); chk("t2_clear", cfg_mode, 0);
    tap(1); chk("t2_dec_wrap", cfg_mode, 4);
    tap(2); chk("t2_clear2", cfg_mode, 0);
    for (int i = 0; i < 5; i++) begin
      tap(0);
      chk("t2_inc_seq", cfg_mode, exp5[i]);
    end

    // long hold of btn0
    n0 = n_rise; p = cyc;
    btn_deb = 4'hE;
    tick(60);
    btn_deb = 4'hF;
    tick(10);
    chk("t3_first_lat", rise_t[n0] - p, 2);
`ifdef BTN_CTRL_REPEAT_EN
    chk("t3_nreq", n_rise - n0, 8);
    chk("t3_gap1", rise_t[n0+1] - rise_t[n0], 21);
    chk("t3_gap2", rise_t[n0+2] - rise_t[n0+1], 6);
    chk("t3_mode", cfg_mode, 3);
`else
    chk("t3_nreq", n_rise - n0, 1);
    chk("t3_mode", cfg_mode, 1);
`endif
    chk("t3_busy", busy, 0);
    tap(2); chk("t3_clear", cfg_mode, 0);

    // slow consumer on enable toggle; btn0 meanwhile ignored
    cfg_ack = 1'b0; n0 = n_rise;
    btn_deb = 4'b0111; tick(2);
    btn_deb = 4'hF;    tick(10);
    btn_deb = 4'hE;    tick(3);
    btn_deb = 4'hF;    tick(35);
    chk("t4_req_held", cfg_req, 1);
    chk("t4_en", cfg_en, 0);
    chk("t4_mode", cfg_mode, 0);
    cfg_ack = 1'b1;
    tick(1); chk("t4_req_ack", cfg_req, 0);
    tick(8);
    chk("t4_busy", busy, 0); chk("t4_mode_after", cfg_mode, 0); chk("t4_nreq", n_rise - n0, 1);

    // simultaneous press and chorded buttons
    n0 = n_rise;
    btn_deb = 4'b1100; tick(2);
    btn_deb = 4'b1110; tick(2);
    btn_deb = 4'b1010; tick(3);
    btn_deb = 4'b1110; tick(2);
    btn_deb = 4'hF;    tick(8);
    chk("t5_prio_mode", cfg_mode, 1); chk("t5_nreq", n_rise - n0, 1); chk("t5_busy", busy, 0);
    n0 = n_rise;
    btn_deb = 4'b1110; tick(2);
    btn_deb = 4'b1010; tick(2);
    btn_deb = 4'b1011; tick(4);
    chk("t5_rel_busy", busy, 1);
    btn_deb = 4'hF;    tick(8);
    chk("t5_mode2", cfg_mode, 2); chk("t5_nreq2", n_rise - n0, 1); chk("t5_busy2", busy, 0);

    // reset while a request is pending at mode 3
    cfg_ack = 1'b0;
    btn_deb = 4'hE; tick(2);
    chk("t6_req", cfg_req, 1); chk("t6_mode", cfg_mode, 3);
    btn_deb = 4'hF; tick(3);
    chk("t6_req_wait", cfg_req, 1);
    rst_n = 1'b0; m_reset();
    #1;
    chk("t6_rst_req", cfg_req, 0); chk("t6_rst_mode", cfg_mode, 0);
    chk("t6_rst_en", cfg_en, 1);   chk("t6_rst_busy", busy, 0);
    cfg_ack = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    tap(0); chk("t6_post_mode", cfg_mode, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
